// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// ARB_HOLD_LIMIT_EN enables the hold-limit preemption in arb.
package arb_pkg;

  localparam int N_REQ      = 4;
  localparam int HOLD_LIMIT = 16;
  localparam int HOLD_W     = $clog2(HOLD_LIMIT);

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input idx_t i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: first set request
// at or after the start pointer, wrapping 3->0.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             start,
  output logic             valid,
  output idx_t             idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  idx_t               off;

  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[N_REQ-1:0];
    off = '0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    valid = |req;
    idx   = start + off;
  end

endmodule

// File: rtl/arb.sv
// 4-way round-robin arbiter with locked grants.
// ARB_HOLD_LIMIT_EN: preempt an owner after HOLD_LIMIT cycles.
module arb
  import arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  output logic ack0,
  output logic ack1,
  output logic ack2,
  output logic ack3
);

  state_e           state_q, state_d;
  idx_t             owner_q, owner_d;
  idx_t             ptr_q, ptr_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] req_v;
  logic [N_REQ-1:0] cand;
  logic             pick_vld;
  idx_t             pick_idx;
  logic             release_own;
  logic             preempt;
`ifdef ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  assign req_v = {req3, req2, req1, req0};

  // The owner is masked so a preempted owner cannot re-win at once.
  assign cand = (state_q == GRANT) ?
                (req_v & ~onehot(owner_q)) : req_v;

  arb_rr_pick u_pick (
    .req   (cand),
    .start (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    release_own = ~req_v[owner_q];
    preempt     = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d      = hold_q;
    preempt     = (hold_q == HOLD_W'(HOLD_LIMIT-1)) &&
                  pick_vld;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick_idx;
          ptr_d   = pick_idx + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (release_own || preempt) begin
          if (pick_vld) begin
            owner_d = pick_idx;
            ptr_d   = pick_idx + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_d  = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_q != HOLD_W'(HOLD_LIMIT-1)) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == GRANT) ? onehot(owner_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  assign ack0 = ack_q[0];
  assign ack1 = ack_q[1];
  assign ack2 = ack_q[2];
  assign ack3 = ack_q[3];

endmodule

// File: tb/tb_arb.sv
// Directed and randomized checks for the round-robin arbiter.
// Covers both ARB_HOLD_LIMIT_EN settings.
module tb_arb;

  logic       clk;
  logic       rst;
  logic       req0, req1, req2, req3;
  logic       ack0, ack1, ack2, ack3;
  logic [3:0] ackv;
  logic [3:0] rq;
  logic [3:0] expv;
  int         compared;
  int         mismatched;
  int         own;
  int         mptr;

  arb dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .req2 (req2),
    .req3 (req3),
    .ack0 (ack0),
    .ack1 (ack1),
    .ack2 (ack2),
    .ack3 (ack3)
  );

  assign ackv = {ack3, ack2, ack1, ack0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: ack=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic apply(input logic [3:0] r);
    rq = r;
    {req3, req2, req1, req0} = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag,
                      input logic [3:0] r,
                      input logic [3:0] want);
    apply(r);
    tick();
    chk(tag, ackv, want);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(4'b0000);
    tick();
    rst = 1'b0;
    own  = -1;
    mptr = 0;
  endtask

  // Independent reference: locked grant, search from pointer.
  task automatic model(input logic [3:0] r,
                       output logic [3:0] e);
    int nxt;
    int c;
    if (!(own >= 0 && r[own])) begin
      nxt = -1;
      for (int k = 0; k < 4; k++) begin
        c = (mptr + k) % 4;
        if (nxt < 0 && r[c] && c != own) nxt = c;
      end
      own = nxt;
      if (nxt >= 0) mptr = (nxt + 1) % 4;
    end
    e = (own >= 0) ? (4'b0001 << own) : 4'b0000;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    apply(4'b0000);
    #12;
    chk("reset_idle", ackv, 4'b0000);
    tick();
    chk("reset_hold", ackv, 4'b0000);
    rst  = 1'b0;
    own  = -1;
    mptr = 0;

    for (int rep = 0; rep < 3; rep++) begin
      step("rr_all",   4'b1111, 4'b0001);
      step("rr_hold0", 4'b1111, 4'b0001);
      step("rr_drop0", 4'b1110, 4'b0010);
      step("rr_drop1", 4'b1100, 4'b0100);
      step("rr_drop2", 4'b1000, 4'b1000);
      step("rr_drop3", 4'b0000, 4'b0000);
      step("rr_idle",  4'b0000, 4'b0000);
    end

    do_reset();
    step("own2",      4'b0100, 4'b0100);
    step("wrap_to0",  4'b0001, 4'b0001);
    step("idle_p1",   4'b0000, 4'b0000);
    step("start_at1", 4'b1011, 4'b0010);
    step("hand_to3",  4'b1001, 4'b1000);
    step("hand_to0",  4'b0001, 4'b0001);

    do_reset();
    step("own1",      4'b0010, 4'b0010);
    step("pulse2",    4'b0110, 4'b0010);
    step("pulse2_dn", 4'b0010, 4'b0010);
    step("no_queue",  4'b0000, 4'b0000);

    step("pre_rst",   4'b1000, 4'b1000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", ackv, 4'b0000);
    tick();
    chk("rst_held", ackv, 4'b0000);
    rst  = 1'b0;
    own  = -1;
    mptr = 0;
    step("post_rst",  4'b1010, 4'b0010);
    step("post_rel",  4'b0000, 4'b0000);

    do_reset();
`ifdef ARB_HOLD_LIMIT_EN
    for (int blk = 0; blk < 3; blk++) begin
      for (int c = 0; c < 16; c++) begin
        step("hold_lim", 4'b0011,
             (blk % 2 == 0) ? 4'b0001 : 4'b0010);
      end
    end
`else
    for (int c = 0; c < 40; c++) begin
      step("locked0", 4'b0011, 4'b0001);
    end
`endif
    step("lock_rel", 4'b0000, 4'b0000);

    do_reset();
    for (int n = 0; n < 10000; n++) begin
      logic [3:0] prev;
      logic [3:0] flip;
      prev = rq;
      flip = 4'($urandom_range(0, 15)) &
             4'($urandom_range(0, 15));
      apply(prev ^ flip);
      tick();
      compared++;
      assert ($onehot0(ackv)) else begin
        mismatched++;
        $error("FAIL rnd_onehot: ack=%b expected=onehot0",
               ackv);
      end
      chk("rnd_noreq", ackv & ~rq, 4'b0000);
`ifndef ARB_HOLD_LIMIT_EN
      model(rq, expv);
      chk("rnd_model", ackv, expv);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
